// File: rtl/adsr_env_poly.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adsr_env_poly : polyphonic ADSR envelope generator, one voice per clock    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module adsr_env_poly #(
  parameter  int VOICES = 4,
  parameter  int W      = 32,
  localparam int VW     = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic              Sys_clk,
  input  logic              Syn_rst_n,
  input  logic              Syn_ce,
  input  logic              Smp_ce,
  input  logic [VOICES-1:0] Syn_key,
  input  logic [W-1:0]      A_lvl,
  input  logic [W-1:0]      S_lvl,
  input  logic [W-1:0]      A_rate,
  input  logic [W-1:0]      D_rate,
  input  logic [W-1:0]      R_rate,
  output logic              Env_valid,
  output logic [VW-1:0]     Env_voice,
  output logic [W-1:0]      Env,
  output logic [2:0]        Env_state,
  output logic [VOICES-1:0] Active,
  output logic              Busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [VW-1:0] LAST = VW'(VOICES - 1);

  logic [VOICES-1:0]        key_q, key_d;
  logic [VOICES-1:0]        rise_pend_q, rise_pend_d;
  logic [VOICES-1:0]        active_q, active_d;
  logic [VOICES-1:0][W-1:0] lvl_q, lvl_d;
  logic [VOICES-1:0][2:0]   st_q, st_d;
  logic                     busy_q, busy_d;
  logic [VW-1:0]            pos_q, pos_d;
  logic                     env_valid_q, env_valid_d;
  logic [VW-1:0]            env_voice_q, env_voice_d;
  logic [W-1:0]             env_q, env_d;
  logic [2:0]               env_state_q, env_state_d;

  logic         start, svc, last;
  state_t       cur_st, nxt_st;
  logic [W-1:0] cur_lvl, nxt_lvl;
  logic [W:0]   add_n, dec_n, rel_n;

  always_comb begin
    start = Syn_ce & Smp_ce & ~busy_q;
    svc   = Syn_ce & busy_q;
    last  = (pos_q == LAST);

    // Retrigger keeps the current level so the attack ramps from there.
    cur_lvl = lvl_q[pos_q];
    cur_st  = state_t'(st_q[pos_q]);
    if (rise_pend_q[pos_q]) begin
      cur_st = S_ATTACK;
    end else if (!Syn_key[pos_q] && (cur_st inside {S_ATTACK, S_DECAY, S_SUSTAIN})) begin
      cur_st = S_RELEASE;
    end

    // One extra bit: carry for the attack sum, borrow (bit W) for the subtractions.
    add_n = {1'b0, cur_lvl} + {1'b0, A_rate};
    dec_n = {1'b0, cur_lvl} - {1'b0, D_rate};
    rel_n = {1'b0, cur_lvl} - {1'b0, R_rate};

    nxt_st  = cur_st;
    nxt_lvl = cur_lvl;
    case (cur_st)
      S_ATTACK: begin
        if (add_n >= {1'b0, A_lvl}) begin
          nxt_lvl = A_lvl;
          nxt_st  = S_DECAY;
        end else begin
          nxt_lvl = add_n[W-1:0];
        end
      end
      S_DECAY: begin
        if (dec_n[W] || (dec_n[W-1:0] <= S_lvl)) begin
          nxt_lvl = S_lvl;
          nxt_st  = S_SUSTAIN;
        end else begin
          nxt_lvl = dec_n[W-1:0];
        end
      end
      S_SUSTAIN: nxt_lvl = S_lvl;
      S_RELEASE: begin
        if (rel_n[W] || (rel_n[W-1:0] == '0)) begin
          nxt_lvl = '0;
          nxt_st  = S_IDLE;
        end else begin
          nxt_lvl = rel_n[W-1:0];
        end
      end
      default: begin
        nxt_lvl = '0;
        nxt_st  = S_IDLE;
      end
    endcase

    // Edge latch runs regardless of Syn_ce; a new rise beats the service clear.
    key_d       = Syn_key;
    rise_pend_d = rise_pend_q;
    if (svc) rise_pend_d[pos_q] = 1'b0;
    rise_pend_d = rise_pend_d | (Syn_key & ~key_q);

    lvl_d       = lvl_q;
    st_d        = st_q;
    active_d    = active_q;
    busy_d      = busy_q;
    pos_d       = pos_q;
    env_valid_d = 1'b0;
    env_voice_d = env_voice_q;
    env_d       = env_q;
    env_state_d = env_state_q;

    if (start) begin
      busy_d = 1'b1;
      pos_d  = '0;
    end else if (svc) begin
      lvl_d[pos_q]    = nxt_lvl;
      st_d[pos_q]     = nxt_st;
      active_d[pos_q] = (nxt_st != S_IDLE);
      env_valid_d     = 1'b1;
      env_voice_d     = pos_q;
      env_d           = nxt_lvl;
      env_state_d     = nxt_st;
      pos_d           = last ? '0 : pos_q + VW'(1);
      busy_d          = ~last;
    end
  end

  always_ff @(posedge Sys_clk or negedge Syn_rst_n) begin
    if (!Syn_rst_n) begin
      key_q       <= '0;
      rise_pend_q <= '0;
      active_q    <= '0;
      lvl_q       <= '0;
      st_q        <= '0;
      busy_q      <= 1'b0;
      pos_q       <= '0;
      env_valid_q <= 1'b0;
      env_voice_q <= '0;
      env_q       <= '0;
      env_state_q <= '0;
    end else begin
      key_q       <= key_d;
      rise_pend_q <= rise_pend_d;
      active_q    <= active_d;
      lvl_q       <= lvl_d;
      st_q        <= st_d;
      busy_q      <= busy_d;
      pos_q       <= pos_d;
      env_valid_q <= env_valid_d;
      env_voice_q <= env_voice_d;
      env_q       <= env_d;
      env_state_q <= env_state_d;
    end
  end

  assign Env_valid = env_valid_q;
  assign Env_voice = env_voice_q;
  assign Env       = env_q;
  assign Env_state = env_state_q;
  assign Active    = active_q;
  assign Busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_adsr_env_poly.sv
`default_nettype none
// tb_adsr_env_poly : envelope sequences from a vector table, timing corners,
// and randomized sweeps against an arithmetic envelope model.
module tb_adsr_env_poly;
  localparam int V  = 4;
  localparam int W  = 32;
  localparam int VW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ce;
  logic          smp;
  logic [V-1:0]  key;
  logic [W-1:0]  a_lvl, s_lvl, a_rate, d_rate, r_rate;
  logic          env_valid;
  logic [VW-1:0] env_voice;
  logic [W-1:0]  env;
  logic [2:0]    env_state;
  logic [V-1:0]  active;
  logic          busy;

  always #5 clk = ~clk;

  adsr_env_poly #(.VOICES(V), .W(W)) dut (
    .Sys_clk(clk), .Syn_rst_n(rst_n), .Syn_ce(ce), .Smp_ce(smp), .Syn_key(key),
    .A_lvl(a_lvl), .S_lvl(s_lvl), .A_rate(a_rate), .D_rate(d_rate), .R_rate(r_rate),
    .Env_valid(env_valid), .Env_voice(env_voice), .Env(env), .Env_state(env_state),
    .Active(active), .Busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: state numbers 0..4 = IDLE, ATTACK, DECAY, SUSTAIN, RELEASE
  longint       m_lvl[V];
  int           m_st[V];
  bit           m_rise[V];
  logic [V-1:0] m_key_prev;
  longint       cap_env[V];
  int           cap_st[V];

  typedef struct {
    bit     key0;
    bit     pulse;
    longint env;
    int     st;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit k, bit p, longint e, int s);
    vec_t r;
    r.key0 = k; r.pulse = p; r.env = e; r.st = s;
    return r;
  endfunction

  function automatic longint u(logic [W-1:0] x);
    return longint'({32'h0, x});
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, env_valid, 0);
    chk({tag, "_voice"}, env_voice, 0);
    chk({tag, "_env"}, env, 0);
    chk({tag, "_state"}, env_state, 0);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic model_reset();
    for (int v = 0; v < V; v++) begin
      m_lvl[v] = 0; m_st[v] = 0; m_rise[v] = 0;
    end
    m_key_prev = '0;
  endtask

  task automatic model_service(input int k, output longint e, output int s);
    longint l, n;
    int     st;
    st = m_st[k];
    l  = m_lvl[k];
    if (m_rise[k]) begin
      st = 1;
      m_rise[k] = 0;
    end else if (!key[k] && st >= 1 && st <= 3) begin
      st = 4;
    end
    case (st)
      1: begin
        n = l + u(a_rate);
        if (n >= u(a_lvl)) begin l = u(a_lvl); st = 2; end else l = n;
      end
      2: begin
        n = l - u(d_rate);
        if (n <= u(s_lvl)) begin l = u(s_lvl); st = 3; end else l = n;
      end
      3: l = u(s_lvl);
      4: begin
        n = l - u(r_rate);
        if (n <= 0) begin l = 0; st = 0; end else l = n;
      end
      default: begin l = 0; st = 0; end
    endcase
    m_st[k] = st;
    m_lvl[k] = l;
    e = l;
    s = st;
  endtask

  task automatic set_keys(input logic [V-1:0] nk);
    @(negedge clk);
    key = nk;
    for (int v = 0; v < V; v++)
      if (nk[v] && !m_key_prev[v]) m_rise[v] = 1;
    m_key_prev = nk;
    @(posedge clk);
  endtask

  function automatic logic [W-1:0] pick_lvl();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom);
      default: return W'($urandom_range(0, 3000));
    endcase
  endfunction

  function automatic logic [W-1:0] pick_rate();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom);
      default: return W'($urandom_range(1, 400));
    endcase
  endfunction

  task automatic rand_params();
    a_lvl = pick_lvl(); s_lvl = pick_lvl();
    a_rate = pick_rate(); d_rate = pick_rate(); r_rate = pick_rate();
  endtask

  // One sample sweep; stall_at / strobe_at name the voice slot to disturb (-1 = none).
  task automatic sweep(input int stall_at, input int strobe_at, input bit mid_rnd);
    longint       e;
    int           s;
    logic [V-1:0] am;
    @(negedge clk); smp = 1'b1;
    @(negedge clk); smp = 1'b0;
    chk("busy_start", busy, 1);
    chk("valid_pre", env_valid, 0);
    for (int k = 0; k < V; k++) begin
      if (k == stall_at) begin
        ce = 1'b0;
        @(negedge clk);
        ce = 1'b1;
        chk("stall_valid", env_valid, 0);
        chk("stall_busy", busy, 1);
      end
      if (k == strobe_at) smp = 1'b1;
      if (mid_rnd && $urandom_range(0, 2) == 0) rand_params();
      model_service(k, e, s);
      @(negedge clk);
      smp = 1'b0;
      for (int v = 0; v < V; v++) am[v] = (m_st[v] != 0);
      chk("valid", env_valid, 1);
      chk("voice", env_voice, k);
      chk("env", env, e);
      chk("state", env_state, s);
      chk("active", active, am);
      chk("busy", busy, (k < V - 1) ? 1 : 0);
      cap_env[k] = e;
      cap_st[k] = s;
    end
    @(negedge clk);
    chk("valid_end", env_valid, 0);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; smp = 1'b0; key = '0;
    a_lvl = 1000; a_rate = 300; d_rate = 100; s_lvl = 600; r_rate = 250;
    model_reset();
    #12;
    check_zero("rst");
    @(negedge clk); rst_n = 1'b1;

    // Voice 0 envelope: attack, decay, sustain, release, retrigger during release
    for (int i = 0; i < 8; i++) ;
    tbl.push_back(mk(1, 0, 300, 1));  tbl.push_back(mk(1, 0, 600, 1));
    tbl.push_back(mk(1, 0, 900, 1));  tbl.push_back(mk(1, 0, 1000, 2));
    tbl.push_back(mk(1, 0, 900, 2));  tbl.push_back(mk(1, 0, 800, 2));
    tbl.push_back(mk(1, 0, 700, 2));  tbl.push_back(mk(1, 0, 600, 3));
    tbl.push_back(mk(1, 0, 600, 3));  tbl.push_back(mk(0, 0, 350, 4));
    tbl.push_back(mk(0, 0, 100, 4));  tbl.push_back(mk(0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0));    tbl.push_back(mk(1, 0, 300, 1));
    tbl.push_back(mk(1, 0, 600, 1));  tbl.push_back(mk(1, 0, 900, 1));
    tbl.push_back(mk(1, 0, 1000, 2)); tbl.push_back(mk(1, 0, 900, 2));
    tbl.push_back(mk(1, 0, 800, 2));  tbl.push_back(mk(1, 0, 700, 2));
    tbl.push_back(mk(1, 0, 600, 3));  tbl.push_back(mk(0, 0, 350, 4));
    tbl.push_back(mk(0, 1, 650, 1));  tbl.push_back(mk(0, 0, 400, 4));
    tbl.push_back(mk(0, 0, 150, 4));  tbl.push_back(mk(0, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].pulse) begin
        set_keys(key | 4'b0001);
        set_keys(key & 4'b1110);
      end
      if (key[0] != tbl[i].key0) set_keys({key[3:1], tbl[i].key0});
      sweep(-1, -1, 1'b0);
      chk("tbl_env", cap_env[0], tbl[i].env);
      chk("tbl_state", cap_st[0], tbl[i].st);
      for (int v = 1; v < V; v++) chk("tbl_quiet", cap_env[v], 0);
    end

    // Timing corners: stall mid-sweep, strobes while busy
    set_keys(4'b1011);
    sweep(1, -1, 1'b0);
    sweep(-1, 1, 1'b0);
    sweep(-1, 3, 1'b0);
    sweep(0, 2, 1'b0);

    // Reset in the middle of a sweep
    set_keys(4'b0110);
    sweep(-1, -1, 1'b0);
    @(negedge clk); smp = 1'b1;
    @(negedge clk); smp = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    model_reset();
    @(negedge clk); key = '0;
    @(negedge clk); rst_n = 1'b1;
    sweep(-1, -1, 1'b0);
    for (int v = 0; v < V; v++) begin
      chk("postrst_env", cap_env[v], 0);
      chk("postrst_state", cap_st[v], 0);
    end

    // Saturation without wrap, then sustain above the attack peak
    a_lvl = '1; a_rate = '1; d_rate = 100; s_lvl = 600; r_rate = 250;
    set_keys(4'b0010);
    sweep(-1, -1, 1'b0);
    chk("sat_env", cap_env[1], 64'hFFFF_FFFF);
    chk("sat_state", cap_st[1], 2);
    a_lvl = 5000;
    set_keys(4'b0110);
    sweep(-1, -1, 1'b0);
    chk("pk_env", cap_env[2], 5000);
    chk("pk_state", cap_st[2], 2);
    s_lvl = 8000;
    sweep(-1, -1, 1'b0);
    chk("sus_env", cap_env[2], 8000);
    chk("sus_state", cap_st[2], 3);

    // Randomized sweeps with live parameter changes
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 2) == 0) set_keys(key ^ V'($urandom_range(0, 15)));
      if ($urandom_range(0, 5) == 0) begin
        logic [V-1:0] pm;
        pm = V'($urandom_range(1, 15));
        set_keys(key & ~pm);
        set_keys(key | pm);
        set_keys(key & ~pm);
      end
      rand_params();
      sweep(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, V - 1)) : -1,
            ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, V - 1)) : -1,
            1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
